// File: rtl/hybrid_counter_bank_pkg.sv
// Shared FSM/lane-mode encodings and default parameters for hybrid_counter_bank.
// Optional overflow tracking is enabled with HYBRID_COUNTER_BANK_OVF_EN.
package hybrid_counter_bank_pkg;

    localparam int DEF_LANES      = 4;
    localparam int DEF_WIDTH      = 41;
    localparam int DEF_SYNC_WIDTH = 4;
    localparam int DEF_SETTLE     = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FREEZE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    // How each lane treats its synchronous carry-out in the current cycle.
    typedef enum logic [1:0] {
        LM_RUN   = 2'd0,
        LM_HOLD  = 2'd1,
        LM_FLUSH = 2'd2,
        LM_DROP  = 2'd3
    } lane_mode_t;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hybrid_counter_lane.sv
// One counter lane: synchronous LSB adder, gated carry into a ripple chain, pending-carry counter.
// Sticky overflow flag on the MSB falling edge exists only with HYBRID_COUNTER_BANK_OVF_EN.
module hybrid_counter_lane
    import hybrid_counter_bank_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SYNC_WIDTH = DEF_SYNC_WIDTH,
    parameter int PEND_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  lane_mode_t            mode,
    input  logic [SYNC_WIDTH-1:0] step,
    output logic [WIDTH-1:0]      count,
    output logic                  pend_zero
`ifdef HYBRID_COUNTER_BANK_OVF_EN
    ,
    output logic                  ovf
`endif
);

    logic [SYNC_WIDTH-1:0] sync_q;
    logic [SYNC_WIDTH-1:0] step_eff;
    logic [SYNC_WIDTH:0]   sum;
    logic                  carry;
    logic                  toggle;
    logic [PEND_WIDTH-1:0] pend_q;
    logic [PEND_WIDTH-1:0] pend_d;
    logic                  rip_lsb_q;
    logic [WIDTH-1:SYNC_WIDTH] rip;

    assign pend_zero = (pend_q == '0);

    always_comb begin
        step_eff = (mode == LM_DROP) ? '0 : step;
        sum      = {1'b0, sync_q} + {1'b0, step_eff};
        carry    = sum[SYNC_WIDTH];
        toggle   = 1'b0;
        pend_d   = pend_q;
        case (mode)
            LM_RUN:  toggle = carry;
            LM_HOLD: pend_d = pend_q + PEND_WIDTH'(carry);
            LM_FLUSH: begin
                // A fresh carry and a drained pending carry share the one toggle.
                toggle = carry | ~pend_zero;
                if (!pend_zero && !carry) begin
                    pend_d = pend_q - PEND_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            pend_q    <= '0;
            rip_lsb_q <= 1'b0;
        end else begin
            sync_q <= sum[SYNC_WIDTH-1:0];
            pend_q <= pend_d;
            if (toggle) begin
                rip_lsb_q <= ~rip_lsb_q;
            end
        end
    end

    assign rip[SYNC_WIDTH] = rip_lsb_q;

    for (genvar i = SYNC_WIDTH + 1; i < WIDTH; i++) begin : g_ripple
        logic bit_q;
        always_ff @(negedge rip[i-1] or negedge rst_n) begin
            if (!rst_n) begin
                bit_q <= 1'b0;
            end else begin
                bit_q <= ~bit_q;
            end
        end
        assign rip[i] = bit_q;
    end

    // Pending carries are folded back in so a capture sees the true total.
    assign count = {rip, sync_q} + (WIDTH'(pend_q) << SYNC_WIDTH);

`ifdef HYBRID_COUNTER_BANK_OVF_EN
    always_ff @(negedge rip[WIDTH-1] or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/hybrid_counter_bank.sv
// Bank of hybrid sync/ripple counters with a freeze-settle-capture-flush snapshot FSM and clear.
// Optional per-lane sticky overflow (snap_ovf) is built only with HYBRID_COUNTER_BANK_OVF_EN.
module hybrid_counter_bank
    import hybrid_counter_bank_pkg::*;
#(
    parameter int  LANES      = DEF_LANES,
    parameter int  WIDTH      = DEF_WIDTH,
    parameter int  SYNC_WIDTH = DEF_SYNC_WIDTH,
    parameter int  SETTLE     = DEF_SETTLE,
    localparam int SEL_WIDTH  = width_of(LANES)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [LANES*SYNC_WIDTH-1:0] step,
    input  logic                        clear,
    input  logic                        snap_req,
    output logic                        snap_ack,
    input  logic [SEL_WIDTH-1:0]        snap_sel,
    output logic [WIDTH-1:0]            snap_count,
    output logic                        busy
`ifdef HYBRID_COUNTER_BANK_OVF_EN
    ,
    output logic                        snap_ovf
`endif
);

    localparam int PEND_WIDTH = $clog2(SETTLE + 3);
    localparam int CNT_WIDTH  = width_of(SETTLE);

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_WIDTH-1:0]   settle_q;
    lane_mode_t             mode;
    logic                   capture;
    logic                   clr_set;
    logic                   clr_q;
    logic                   lane_rst_n;
    logic                   all_pend_zero;
    logic [LANES-1:0]       lane_pend_zero;
    logic [WIDTH-1:0]       lane_count [LANES];
    logic [WIDTH-1:0]       shadow_q   [LANES];

    assign busy          = (state_q != ST_IDLE);
    assign all_pend_zero = &lane_pend_zero;
    // Registered clear pulse doubles as an asynchronous reset for every lane bit.
    assign lane_rst_n    = reset_n & ~clr_q;

    always_comb begin
        state_d = state_q;
        mode    = LM_RUN;
        capture = 1'b0;
        clr_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    clr_set = 1'b1;
                end else if (snap_req) begin
                    state_d = ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                mode = LM_HOLD;
                if (settle_q == CNT_WIDTH'(SETTLE - 1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                mode    = LM_HOLD;
                capture = 1'b1;
                state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                mode = LM_FLUSH;
                if (all_pend_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                mode    = LM_DROP;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            clr_q    <= 1'b0;
            snap_ack <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= (state_q == ST_FREEZE) ? settle_q + CNT_WIDTH'(1) : '0;
            clr_q    <= clr_set;
            snap_ack <= capture;
        end
    end

`ifdef HYBRID_COUNTER_BANK_OVF_EN
    logic [LANES-1:0] lane_ovf;
    logic [LANES-1:0] shadow_ovf_q;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        hybrid_counter_lane #(
            .WIDTH      (WIDTH),
            .SYNC_WIDTH (SYNC_WIDTH),
            .PEND_WIDTH (PEND_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst_n     (lane_rst_n),
            .mode      (mode),
            .step      (enable ? step[k*SYNC_WIDTH +: SYNC_WIDTH] : '0),
            .count     (lane_count[k]),
            .pend_zero (lane_pend_zero[k])
`ifdef HYBRID_COUNTER_BANK_OVF_EN
            ,
            .ovf       (lane_ovf[k])
`endif
        );
    end

    // Shadows sit on the global reset only, so a clear leaves the last snapshot intact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LANES; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < LANES; k++) begin
                shadow_q[k] <= lane_count[k];
            end
        end
    end

    always_comb begin
        snap_count = '0;
        for (int k = 0; k < LANES; k++) begin
            if (snap_sel == SEL_WIDTH'(k)) begin
                snap_count = shadow_q[k];
            end
        end
    end

`ifdef HYBRID_COUNTER_BANK_OVF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_ovf_q <= '0;
        end else if (capture) begin
            shadow_ovf_q <= lane_ovf;
        end
    end

    always_comb begin
        snap_ovf = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (snap_sel == SEL_WIDTH'(k)) begin
                snap_ovf = shadow_ovf_q[k];
            end
        end
    end
`endif

endmodule

// File: tb/tb_hybrid_counter_bank.sv
// Directed self-checking bench for hybrid_counter_bank (default build plus a WIDTH=8 instance).
// Overflow checks are included when HYBRID_COUNTER_BANK_OVF_EN is defined.
module tb_hybrid_counter_bank;

    localparam int L   = 4;
    localparam int S   = 4;
    localparam int SET = 4;
    localparam int W   = 41;
    localparam int W8  = 8;

    logic           clk      = 1'b0;
    logic           reset_n  = 1'b1;
    logic           enable   = 1'b0;
    logic           clear    = 1'b0;
    logic           snap_req = 1'b0;
    logic [L*S-1:0] step     = '0;
    logic [1:0]     snap_sel = '0;
    logic           snap_ack;
    logic           busy;
    logic [W-1:0]   snap_count;

    logic           clear8    = 1'b0;
    logic           snap_req8 = 1'b0;
    logic [L*S-1:0] step8     = '0;
    logic [1:0]     snap_sel8 = '0;
    logic           snap_ack8;
    logic           busy8;
    logic [W8-1:0]  snap_count8;

`ifdef HYBRID_COUNTER_BANK_OVF_EN
    logic           snap_ovf;
    logic           snap_ovf8;
`endif

    int total = 0;
    int bad   = 0;
    int cont_total = 0;

    always #5 clk = ~clk;

    hybrid_counter_bank dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .step       (step),
        .clear      (clear),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .snap_sel   (snap_sel),
        .snap_count (snap_count),
        .busy       (busy)
`ifdef HYBRID_COUNTER_BANK_OVF_EN
        ,
        .snap_ovf   (snap_ovf)
`endif
    );

    hybrid_counter_bank #(.WIDTH(W8)) dut8 (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .step       (step8),
        .clear      (clear8),
        .snap_req   (snap_req8),
        .snap_ack   (snap_ack8),
        .snap_sel   (snap_sel8),
        .snap_count (snap_count8),
        .busy       (busy8)
`ifdef HYBRID_COUNTER_BANK_OVF_EN
        ,
        .snap_ovf   (snap_ovf8)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap_main(output int lat);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        lat = 1;
        while (snap_ack !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        #2;
        reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++;
        if (snap_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b expected 0", snap_ack); end
        for (int k = 0; k < L; k++) begin
            snap_sel = 2'(k);
            #1;
            total++;
            if (snap_count !== '0) begin
                bad++; $display("FAIL reset_shadow lane%0d: got %0d expected 0", k, snap_count);
            end
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        int exp_cnt [L];
        exp_cnt = '{300, 0, 0, 0};
        enable = 1'b1;
        step   = '0;
        step[3:0] = 4'd3;
        repeat (100) tick();
        step = '0;
        snap_main(lat);
        total++;
        if (lat !== SET + 2) begin bad++; $display("FAIL ack_latency: got %0d expected %0d", lat, SET + 2); end
        tick();
        total++;
        if (snap_ack !== 1'b0) begin bad++; $display("FAIL ack_pulse_width: got %b expected 0", snap_ack); end
        wait_idle();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle: got %b expected 0", busy); end
        for (int k = 0; k < L; k++) begin
            snap_sel = 2'(k);
            #1;
            total++;
            if (snap_count !== W'(exp_cnt[k])) begin
                bad++; $display("FAIL basic_count lane%0d: got %0d expected %0d", k, snap_count, exp_cnt[k]);
            end
        end
    endtask

    task automatic test_enable();
        int lat;
        enable = 1'b0;
        step[11:8] = 4'd5;
        repeat (10) tick();
        enable = 1'b1;
        repeat (4) tick();
        step = '0;
        snap_main(lat);
        wait_idle();
        snap_sel = 2'd2;
        #1;
        total++;
        if (snap_count !== W'(20)) begin bad++; $display("FAIL enable_gate lane2: got %0d expected 20", snap_count); end
        snap_sel = 2'd0;
        #1;
        total++;
        if (snap_count !== W'(300)) begin bad++; $display("FAIL enable_hold lane0: got %0d expected 300", snap_count); end
    endtask

    task automatic test_continuous();
        int edges;
        int cap_edges;
        int n;
        int lat;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        enable = 1'b1;
        step   = {L{4'hF}};
        edges  = 0;
        repeat (20) begin tick(); edges++; end
        snap_req = 1'b1;
        tick();
        edges++;
        snap_req = 1'b0;
        cap_edges = edges + SET;
        n = 0;
        while (snap_ack !== 1'b1 && n < 40) begin tick(); edges++; n++; end
        total++;
        if (snap_ack !== 1'b1) begin bad++; $display("FAIL cont_ack: got %b expected 1", snap_ack); end
        for (int k = 0; k < L; k++) begin
            snap_sel = 2'(k);
            #1;
            total++;
            if (snap_count !== W'(15 * cap_edges)) begin
                bad++; $display("FAIL cont_capture lane%0d: got %0d expected %0d", k, snap_count, 15 * cap_edges);
            end
        end
        while (edges < 71) begin tick(); edges++; end
        n = 0;
        while (busy !== 1'b0 && n < 400) begin tick(); edges++; n++; end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL cont_flush_done: got %b expected 0", busy); end
        step = '0;
        tick();
        snap_main(lat);
        wait_idle();
        cont_total = 15 * edges;
        for (int k = 0; k < L; k++) begin
            snap_sel = 2'(k);
            #1;
            total++;
            if (snap_count !== W'(cont_total)) begin
                bad++; $display("FAIL cont_final lane%0d: got %0d expected %0d", k, snap_count, cont_total);
            end
        end
    endtask

    task automatic test_clear_snap();
        int acks;
        int lat;
        step = '0;
        step[3:0] = 4'd3;
        repeat (10) tick();
        clear    = 1'b1;
        snap_req = 1'b1;
        tick();
        clear    = 1'b0;
        snap_req = 1'b0;
        acks = int'(snap_ack);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL clear_state_busy: got %b expected 1", busy); end
        tick();
        step = '0;
        acks += int'(snap_ack);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL clear_one_cycle: got %b expected 0", busy); end
        for (int k = 0; k < L; k += 3) begin
            snap_sel = 2'(k);
            #1;
            total++;
            if (snap_count !== W'(cont_total)) begin
                bad++; $display("FAIL clear_keeps_shadow lane%0d: got %0d expected %0d", k, snap_count, cont_total);
            end
        end
        repeat (10) begin tick(); acks += int'(snap_ack); end
        total++;
        if (acks !== 0) begin bad++; $display("FAIL clear_no_ack: got %0d expected 0", acks); end
        snap_main(lat);
        wait_idle();
        for (int k = 0; k < L; k++) begin
            snap_sel = 2'(k);
            #1;
            total++;
            if (snap_count !== '0) begin
                bad++; $display("FAIL clear_zeroed lane%0d: got %0d expected 0", k, snap_count);
            end
        end
    endtask

    task automatic test_repeat();
        int acks;
        int lat;
        step = '0;
        step[15:12] = 4'd2;
        snap_req = 1'b1;
        acks = 0;
        for (int i = 0; i < SET + 2; i++) begin
            clear = (i == 2);
            tick();
            acks += int'(snap_ack);
        end
        snap_req = 1'b0;
        clear    = 1'b0;
        step     = '0;
        repeat (40) begin tick(); acks += int'(snap_ack); end
        total++;
        if (acks !== 1) begin bad++; $display("FAIL repeat_one_ack: got %0d expected 1", acks); end
        snap_sel = 2'd3;
        #1;
        total++;
        if (snap_count !== W'(10)) begin bad++; $display("FAIL repeat_capture lane3: got %0d expected 10", snap_count); end
        snap_main(lat);
        wait_idle();
        snap_sel = 2'd3;
        #1;
        total++;
        if (snap_count !== W'(12)) begin bad++; $display("FAIL repeat_clear_ignored lane3: got %0d expected 12", snap_count); end
    endtask

    task automatic test_reset_mid();
        int acks;
        int lat;
        step = {L{4'd1}};
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        step    = '0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        total++;
        if (snap_ack !== 1'b0) begin bad++; $display("FAIL rstmid_ack: got %b expected 0", snap_ack); end
        snap_sel = 2'd3;
        #1;
        total++;
        if (snap_count !== '0) begin bad++; $display("FAIL rstmid_shadow lane3: got %0d expected 0", snap_count); end
        repeat (2) tick();
        reset_n = 1'b1;
        acks = 0;
        repeat (SET + 4) begin tick(); acks += int'(snap_ack); end
        total++;
        if (acks !== 0) begin bad++; $display("FAIL rstmid_no_ack: got %0d expected 0", acks); end
        snap_main(lat);
        total++;
        if (lat !== SET + 2) begin bad++; $display("FAIL rstmid_relatency: got %0d expected %0d", lat, SET + 2); end
        wait_idle();
        for (int k = 0; k < L; k++) begin
            snap_sel = 2'(k);
            #1;
            total++;
            if (snap_count !== '0) begin
                bad++; $display("FAIL rstmid_counts lane%0d: got %0d expected 0", k, snap_count);
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        enable = 1'b1;
        step8  = '0;
        step8[7:4] = 4'd1;
        repeat (260) tick();
        step8 = '0;
        tick();
        snap_req8 = 1'b1;
        tick();
        snap_req8 = 1'b0;
        n = 0;
        while (snap_ack8 !== 1'b1 && n < 60) begin tick(); n++; end
        total++;
        if (snap_ack8 !== 1'b1) begin bad++; $display("FAIL wrap_ack: got %b expected 1", snap_ack8); end
        n = 0;
        while (busy8 !== 1'b0 && n < 100) begin tick(); n++; end
        snap_sel8 = 2'd1;
        #1;
        total++;
        if (snap_count8 !== 8'd4) begin bad++; $display("FAIL wrap_count lane1: got %0d expected 4", snap_count8); end
`ifdef HYBRID_COUNTER_BANK_OVF_EN
        total++;
        if (snap_ovf8 !== 1'b1) begin bad++; $display("FAIL wrap_ovf lane1: got %b expected 1", snap_ovf8); end
`endif
        snap_sel8 = 2'd0;
        #1;
        total++;
        if (snap_count8 !== 8'd0) begin bad++; $display("FAIL wrap_count lane0: got %0d expected 0", snap_count8); end
`ifdef HYBRID_COUNTER_BANK_OVF_EN
        total++;
        if (snap_ovf8 !== 1'b0) begin bad++; $display("FAIL wrap_ovf lane0: got %b expected 0", snap_ovf8); end
`endif
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_enable();
        test_continuous();
        test_clear_snap();
        test_repeat();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hybrid_counter_bank.md
HYBRID_COUNTER_BANK -- requirements
Module: hybrid_counter_bank

Interface
REQ-001 Parameter LANES, default 4: number of independent counter lanes, minimum 1.
REQ-002 Parameter WIDTH, default 41: bits per lane counter, shall exceed SYNC_WIDTH+1.
REQ-003 Parameter SYNC_WIDTH, default 4: synchronous LSB bits per lane; also the per-lane step width.
REQ-004 Parameter SETTLE, default 4: ripple-settle cycles during a snapshot, minimum 1.
REQ-005 clk  input  1  single clock for all synchronous logic.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  when low, all lane steps are treated as zero.
REQ-008 step  input  LANES*SYNC_WIDTH  per-lane increment; lane k occupies bits [k*SYNC_WIDTH +: SYNC_WIDTH].
REQ-009 clear  input  1  single-cycle request to zero all lane counters.
REQ-010 snap_req  input  1  single-cycle request to capture all lanes coherently.
REQ-011 snap_ack  output  1  one-cycle pulse when the shadow registers hold a new snapshot.
REQ-012 snap_sel  input  clog2(LANES) (min 1)  selects the lane shown on snap_count.
REQ-013 snap_count  output  WIDTH  shadow value of the selected lane, combinational from snap_sel.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Each lane shall add step to its SYNC_WIDTH synchronous bits every clk edge, modulo 2^SYNC_WIDTH; the carry-out shall toggle ripple bit SYNC_WIDTH.
REQ-016 Bits above SYNC_WIDTH shall form an asynchronous ripple chain: bit i toggles on the falling edge of bit i-1.
REQ-017 Counter wrap from all-ones shall give zero with no saturation.
REQ-018 The FSM shall have states IDLE, FREEZE, CAPTURE, FLUSH, CLEAR.
REQ-019 When snap_req is sampled high in IDLE at edge N, the FSM shall enter FREEZE and remain there for SETTLE cycles, then go to CAPTURE.
REQ-020 In FREEZE and CAPTURE, carry-outs shall not toggle the ripple chain; each lane shall add them to a pending-carry counter of clog2(SETTLE+3) bits.
REQ-021 In CAPTURE (edge N+SETTLE+1), all lanes' full counts shall be copied to the shadow registers, and snap_ack shall be high for the following cycle.
REQ-022 In FLUSH, each lane with nonzero pending shall toggle its ripple LSB once per cycle and decrement pending; a simultaneous new carry shall leave pending unchanged.
REQ-023 The FSM shall return from FLUSH to IDLE on the cycle in which all pending counters are zero; no carries shall be lost.
REQ-024 snap_req and clear shall be ignored outside IDLE.
REQ-025 When clear and snap_req are both high in IDLE, clear shall win.
REQ-026 clear in IDLE shall enter CLEAR for one cycle, then return to IDLE; a registered pulse shall asynchronously zero every lane bit and pending counter; steps arriving in that cycle shall be discarded.
REQ-027 Shadow registers shall not be altered by clear.

Reset
REQ-028 While reset_n is low: all lane counters, pending counters and shadow registers = 0; FSM = IDLE; snap_ack = 0; busy = 0.
REQ-029 Reset mid-snapshot shall abort the snapshot with no snap_ack.

Configuration
REQ-030 With HYBRID_COUNTER_BANK_OVF_EN defined, each lane shall set a sticky overflow flag on the falling edge of bit WIDTH-1.
REQ-031 With HYBRID_COUNTER_BANK_OVF_EN defined, the flag shall be captured into the shadow registers at CAPTURE.
REQ-032 With HYBRID_COUNTER_BANK_OVF_EN defined, the flag shall be cleared by clear or reset and exposed on an extra output snap_ovf (1 bit, selected by snap_sel).
REQ-033 Without HYBRID_COUNTER_BANK_OVF_EN, snap_ovf and its logic shall be absent.

Structure
REQ-034 A shared package shall hold the FSM state encoding and the default parameter constants.
REQ-035 A single-lane sub-module hybrid_counter_lane (sync adder, carry gate, pending counter, ripple chain) shall be instantiated LANES times by a generate loop.

Verification
REQ-036 reset_n low then high; enable=1; lane0 step=3 for 100 cycles; snapshot -> lane0 reads 300, other lanes 0, snap_ack pulse at cycle SETTLE+2 after snap_req.
REQ-037 Steady step=15 on all lanes; snap_req; keep stepping 50 cycles -> shadow equals the count at CAPTURE; final snapshot equals 15 x total cycles (no lost carries through FREEZE/FLUSH).
REQ-038 WIDTH=8 with macro defined; lane1 step=1 for 260 cycles -> snapshot 4 with snap_ovf=1; lane0 snap_ovf=0.
REQ-039 clear and snap_req high together in IDLE -> counters zero, no snap_ack, previous shadow values retained.
REQ-040 reset_n low during FREEZE -> busy=0 immediately, no snap_ack, all counts 0.
REQ-041 snap_req repeated while busy -> ignored; exactly one snap_ack per accepted request.
